// File: rtl/k054539_host_bus_if.sv
// Request/response and pin bundle for the 054539 host-bus initiator.
// The master modport belongs to the initiator; the slave side is the CPU/chip environment.
interface k054539_host_bus_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [9:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_done;
    logic [7:0] rsp_data;
    logic       rsp_tmo;
    logic       pin_ab09;
    logic [7:0] pin_ab;
    logic [7:0] pin_db_out;
    logic       pin_db_oe;
    logic [7:0] pin_db_in;
    logic       pin_ncs;
    logic       pin_nrd;
    logic       pin_nwr;
    logic       pin_wait;

    modport master (
        input  req_valid, req_wr, req_addr, req_data, pin_db_in, pin_wait,
        output req_ready, rsp_done, rsp_data, rsp_tmo,
               pin_ab09, pin_ab, pin_db_out, pin_db_oe, pin_ncs, pin_nrd, pin_nwr
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_data, pin_db_in, pin_wait,
        input  req_ready, rsp_done, rsp_data, rsp_tmo,
               pin_ab09, pin_ab, pin_db_out, pin_db_oe, pin_ncs, pin_nrd, pin_nwr
    );
endinterface

// File: rtl/k054539_host_bus.sv
// CPU-side bus initiator for the 054539 register port: one request becomes one
// SETUP/CS/STB/HOLD/GAP pin cycle, with WAIT-extended strobes bounded by a timeout.
module k054539_host_bus #(
    parameter int T_ADDR = 1,
    parameter int T_CS   = 2,
    parameter int T_STB  = 8,
    parameter int T_HOLD = 1,
    parameter int T_GAP  = 4,
    parameter int T_TMO  = 255
) (
    input  logic               clk,
    input  logic               res,
    k054539_host_bus_if.master bus
);

    localparam logic [7:0] LD_ADDR = 8'(T_ADDR - 1);
    localparam logic [7:0] LD_CS   = 8'(T_CS - 1);
    localparam logic [7:0] LD_STB  = 8'(T_STB - 1);
    localparam logic [7:0] LD_HOLD = 8'(T_HOLD - 1);
    localparam logic [7:0] LD_GAP  = 8'(T_GAP - 1);
    localparam logic [7:0] LD_TMO  = 8'(T_TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CS, S_STB, S_HOLD, S_GAP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ext_q, ext_d;     // strobe is in its WAIT extension phase
    logic       tmo_q, tmo_d;     // current cycle's strobe ended by timeout
    logic       wr_q, wr_d;
    logic       wait_s1, wait_s2;
    logic       accept, stb_end, last;

    logic       ncs_q, nrd_q, nwr_q, oe_q, ready_q, done_q, rsp_tmo_q;
    logic       ncs_d, nrd_d, nwr_d, oe_d, ready_d, done_d;
    logic       ab09_q;
    logic [7:0] ab_q, dout_q, rsp_data_q;

    // Address bit 8 has no pin on this port.
    logic unused_addr_bit;
    assign unused_addr_bit = bus.req_addr[8];

    assign accept = (state_q == S_IDLE) && bus.req_valid && ready_q;
    assign last   = (cnt_q == 8'd0);

    // NOTE: every variable written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ext_d   = ext_q;
        tmo_d   = tmo_q;
        stb_end = 1'b0;
        wr_d    = accept ? bus.req_wr : wr_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SETUP;
                    cnt_d   = LD_ADDR;
                    ext_d   = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            S_SETUP: begin
                if (last) begin
                    state_d = S_CS;
                    cnt_d   = LD_CS;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_CS: begin
                if (last) begin
                    state_d = S_STB;
                    cnt_d   = LD_STB;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_STB: begin
                // Minimum width first; WAIT is only looked at in its final counted cycle
                // and then through the extension, which reuses the counter for T_TMO.
                if (!ext_q) begin
                    if (!last) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (!wait_s2) begin
                        ext_d = 1'b1;
                        cnt_d = LD_TMO;
                    end else begin
                        stb_end = 1'b1;
                    end
                end else if (wait_s2) begin
                    stb_end = 1'b1;
                end else if (last) begin
                    stb_end = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
                if (stb_end) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                    ext_d   = 1'b0;
                end
            end
            S_HOLD: begin
                if (last) begin
                    state_d = S_GAP;
                    cnt_d   = LD_GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (last) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pin levels are derived from the next state so they switch on the same edge as the FSM.
        ncs_d   = !(state_d inside {S_CS, S_STB, S_HOLD});
        nrd_d   = !((state_d == S_STB) && !wr_d);
        nwr_d   = !((state_d == S_STB) && wr_d);
        oe_d    = wr_d && (state_d inside {S_SETUP, S_CS, S_STB, S_HOLD});
        ready_d = (state_d == S_IDLE);
        done_d  = (state_q == S_HOLD) && (state_d == S_GAP);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            ext_q      <= 1'b0;
            tmo_q      <= 1'b0;
            wr_q       <= 1'b0;
            wait_s1    <= 1'b1;
            wait_s2    <= 1'b1;
            ncs_q      <= 1'b1;
            nrd_q      <= 1'b1;
            nwr_q      <= 1'b1;
            oe_q       <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            rsp_tmo_q  <= 1'b0;
            ab09_q     <= 1'b0;
            ab_q       <= 8'd0;
            dout_q     <= 8'd0;
            rsp_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ext_q     <= ext_d;
            tmo_q     <= tmo_d;
            wr_q      <= wr_d;
            wait_s1   <= bus.pin_wait;
            wait_s2   <= wait_s1;
            ncs_q     <= ncs_d;
            nrd_q     <= nrd_d;
            nwr_q     <= nwr_d;
            oe_q      <= oe_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            rsp_tmo_q <= done_d && tmo_d;
            if (accept) begin
                ab09_q <= bus.req_addr[9];
                ab_q   <= bus.req_addr[7:0];
                dout_q <= bus.req_data;
            end
            // Read data is taken on the edge where NRD rises, even after a timeout.
            if (stb_end && !wr_q) begin
                rsp_data_q <= bus.pin_db_in;
            end
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.rsp_done   = done_q;
    assign bus.rsp_tmo    = rsp_tmo_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.pin_ab09   = ab09_q;
    assign bus.pin_ab     = ab_q;
    assign bus.pin_db_out = dout_q;
    assign bus.pin_db_oe  = oe_q;
    assign bus.pin_ncs    = ncs_q;
    assign bus.pin_nrd    = nrd_q;
    assign bus.pin_nwr    = nwr_q;

endmodule

// File: tb/tb_k054539_host_bus.sv
// Self-checking bench for k054539_host_bus: directed and random register cycles
// compared against a timing/data model built from phase durations and WAIT rules.
module tb_k054539_host_bus;

    localparam int T_ADDR = 1;
    localparam int T_CS   = 2;
    localparam int T_STB  = 8;
    localparam int T_HOLD = 1;
    localparam int T_GAP  = 4;
    localparam int T_TMO  = 255;
    localparam int T_TOTAL = T_ADDR + T_CS + T_STB + T_HOLD + T_GAP;

    logic clk = 1'b0;
    logic res;
    logic wait_n;
    logic [7:0] chip_val;

    k054539_host_bus_if bus ();

    k054539_host_bus #(
        .T_ADDR(T_ADDR), .T_CS(T_CS), .T_STB(T_STB),
        .T_HOLD(T_HOLD), .T_GAP(T_GAP), .T_TMO(T_TMO)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Chip model: drives its register value only while NRD is low.
    assign bus.pin_db_in = bus.pin_nrd ? 8'hFF : chip_val;
    assign bus.pin_wait  = wait_n;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pin monitor: strobe widths, what the pins showed at strobe start, NCS-high runs, done pulses.
    int         stb_run = 0, last_stb = 0, cs_pre = 0, snap_cs_pre = 0;
    int         hi_run = 0, last_hi = 0, done_cnt = 0, illegal = 0;
    logic       snap_wr = 1'b0, snap_ab09 = 1'b0, snap_oe = 1'b0;
    logic [7:0] snap_ab = 8'd0, snap_dout = 8'd0;
    wire        strobe_lo = !bus.pin_nrd || !bus.pin_nwr;

    always @(negedge clk) begin
        if (strobe_lo) begin
            stb_run <= stb_run + 1;
            if (stb_run == 0) begin
                snap_wr     <= !bus.pin_nwr;
                snap_ab09   <= bus.pin_ab09;
                snap_ab     <= bus.pin_ab;
                snap_oe     <= bus.pin_db_oe;
                snap_dout   <= bus.pin_db_out;
                snap_cs_pre <= cs_pre;
            end
        end else if (stb_run != 0) begin
            last_stb <= stb_run;
            stb_run  <= 0;
        end
        if (bus.pin_ncs) cs_pre <= 0;
        else if (!strobe_lo && stb_run == 0) cs_pre <= cs_pre + 1;
        if (bus.pin_ncs) hi_run <= hi_run + 1;
        else if (hi_run != 0) begin
            last_hi <= hi_run;
            hi_run  <= 0;
        end
        if (bus.rsp_done) done_cnt <= done_cnt + 1;
        if ((!bus.pin_nrd && !bus.pin_nwr) || (strobe_lo && bus.pin_ncs)) illegal <= illegal + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe width for WAIT held low for wait_lo cycles from strobe start: the
    // synchroniser makes the low level visible for strobe cycles 3..wait_lo+2.
    function automatic int exp_stb(input int wait_lo);
        int n;
        if (wait_lo == 0) return T_STB;
        n = wait_lo + 3;
        if (n < T_STB) n = T_STB;
        if (n > T_STB + T_TMO) n = T_STB + T_TMO;
        return n;
    endfunction

    logic [7:0] exp_rsp = 8'd0;
    int         last_acc = 0;

    task automatic do_txn(input logic wr, input logic [9:0] addr, input logic [7:0] data,
                          input logic [7:0] chip, input int wait_lo, input logic keep);
        int         acc, t, done_t, ready_t, exp_len, dc0;
        logic       seen, got_tmo, exp_tmo;
        logic [7:0] got_data;
        seen = 1'b0; got_tmo = 1'b0; got_data = 8'd0; done_t = 0; ready_t = 0;
        for (int g = 0; g < 400 && !bus.req_ready; g++) @(negedge clk);
        chk("ready_before_req", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_data  = data;
        chip_val      = chip;
        dc0           = done_cnt;
        @(posedge clk);
        @(negedge clk);
        acc      = cyc;
        last_acc = acc;
        if (!keep) bus.req_valid = 1'b0;
        chk("ready_after_accept", bus.req_ready, 1'b0);
        for (int g = 0; g < 600; g++) begin
            t = cyc - acc;
            if (wait_lo > 0 && t == T_ADDR + T_CS) wait_n = 1'b0;
            if (wait_lo > 0 && t == T_ADDR + T_CS + wait_lo) wait_n = 1'b1;
            if (bus.rsp_done) begin
                seen = 1'b1; done_t = t; got_tmo = bus.rsp_tmo; got_data = bus.rsp_data;
                break;
            end
            @(negedge clk);
        end
        wait_n = 1'b1;
        for (int g = 0; g < 100; g++) begin
            if (bus.req_ready) begin
                ready_t = cyc - acc;
                break;
            end
            @(negedge clk);
        end
        exp_len = exp_stb(wait_lo);
        exp_tmo = (wait_lo > 0) && (wait_lo + 3 > T_STB + T_TMO);
        if (!wr) exp_rsp = chip;
        chk("done_seen", seen, 1'b1);
        chk("done_time", done_t, T_ADDR + T_CS + exp_len + T_HOLD);
        chk("ready_time", ready_t, T_ADDR + T_CS + exp_len + T_HOLD + T_GAP);
        chk("done_pulses", done_cnt - dc0, 1);
        chk("rsp_tmo", got_tmo, exp_tmo);
        chk("rsp_data", got_data, exp_rsp);
        chk("strobe_len", last_stb, exp_len);
        chk("strobe_kind", snap_wr, wr);
        chk("cs_to_strobe", snap_cs_pre, T_CS);
        chk("pin_ab09", snap_ab09, addr[9]);
        chk("pin_ab", snap_ab, addr[7:0]);
        chk("pin_db_oe", snap_oe, wr);
        if (wr) chk("pin_db_out", snap_dout, data);
    endtask

    initial begin
        int acc1, dc0;
        res = 1'b1;
        wait_n = 1'b1;
        chip_val = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 10'd0;
        bus.req_data  = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ncs", bus.pin_ncs, 1'b1);
        chk("rst_nrd", bus.pin_nrd, 1'b1);
        chk("rst_nwr", bus.pin_nwr, 1'b1);
        chk("rst_db_oe", bus.pin_db_oe, 1'b0);
        chk("rst_ab09", bus.pin_ab09, 1'b0);
        chk("rst_ab", bus.pin_ab, 8'h00);
        chk("rst_db_out", bus.pin_db_out, 8'h00);
        chk("rst_done", bus.rsp_done, 1'b0);
        chk("rst_tmo", bus.rsp_tmo, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, 8'h00);
        res = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.req_ready, 1'b1);

        // Directed cycles: plain write, plain read, short WAIT, long WAIT
        do_txn(1'b1, 10'h050, 8'h11, 8'h00, 0, 1'b0);
        do_txn(1'b0, 10'h21B, 8'h00, 8'h10, 0, 1'b0);
        do_txn(1'b1, 10'h222, 8'h06, 8'h00, 5, 1'b0);
        do_txn(1'b1, 10'h1C3, 8'h77, 8'h00, 12, 1'b0);
        do_txn(1'b0, 10'h105, 8'h00, 8'hA6, 9, 1'b0);

        // WAIT stuck low: timeout, then a normal read
        do_txn(1'b1, 10'h300, 8'h3C, 8'h00, 1000, 1'b0);
        do_txn(1'b0, 10'h0FF, 8'h00, 8'h5D, 0, 1'b0);

        // Back-to-back writes with REQ_VALID held
        do_txn(1'b1, 10'h21B, 8'h10, 8'h00, 0, 1'b1);
        acc1 = last_acc;
        do_txn(1'b1, 10'h21C, 8'h15, 8'h00, 0, 1'b0);
        chk("b2b_accept_spacing", last_acc - acc1, T_TOTAL + 1);
        chk("b2b_ncs_high", last_hi, T_GAP + 1 + T_ADDR);

        // Reset in the middle of a strobe
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 10'h1A5;
        bus.req_data  = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        dc0 = done_cnt;
        for (int g = 0; g < 20 && bus.pin_nwr; g++) @(negedge clk);
        chk("rst_mid_strobe_reached", bus.pin_nwr, 1'b0);
        repeat (3) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        chk("rst_mid_ncs", bus.pin_ncs, 1'b1);
        chk("rst_mid_nwr", bus.pin_nwr, 1'b1);
        chk("rst_mid_db_oe", bus.pin_db_oe, 1'b0);
        chk("rst_mid_done", bus.rsp_done, 1'b0);
        res = 1'b0;
        exp_rsp = 8'h00;
        @(negedge clk);
        chk("rst_mid_ready", bus.req_ready, 1'b1);
        chk("rst_mid_rsp_data", bus.rsp_data, exp_rsp);
        repeat (16) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - dc0, 0);
        do_txn(1'b0, 10'h2A0, 8'h00, 8'hC3, 0, 1'b0);

        // Random cycles with assorted WAIT patterns
        for (int i = 0; i < 20; i++) begin
            logic       wr;
            logic [9:0] addr;
            logic [7:0] data, chip;
            int         wl;
            wr   = 1'($urandom_range(0, 1));
            addr = 10'($urandom_range(0, 1023));
            data = 8'($urandom_range(0, 255));
            chip = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                1:       wl = $urandom_range(1, 5);
                2:       wl = $urandom_range(6, 20);
                default: wl = 0;
            endcase
            do_txn(wr, addr, data, chip, wl, 1'b0);
        end

        chk("strobe_rules", illegal, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
